dmemx: RTL
==========

# dmemx

Parametrised data memory for the MIPS core, replacing the fixed 64-word, single-cycle, word-only data memory. Accepts one request at a time through a req/ready handshake with a programmable wait-state count, supports byte/halfword/word loads and stores with sign or zero extension, and flags misaligned, out-of-range or bad-size accesses instead of silently aliasing. Sits between the core's memory stage and the on-chip RAM; the core stalls while `busy` is high.

## Interface
Parameters:
- `ADDR_W`, 6, word-address bits; depth = 2**ADDR_W words of 32 bits.
- `WAIT_CYCLES`, 1, extra wait states per access, legal 0..15.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req` in 1: request valid; sampled only when the block can accept.
- `we` in 1: 1 = store, 0 = load.
- `size` in 2: 00 byte, 01 halfword, 10 word, 11 illegal.
- `sign` in 1: loads only; 1 = sign-extend, 0 = zero-extend.
- `addr` in 32: byte address.
- `wdata` in 32: store data, right-justified (byte in [7:0], half in [15:0]).
- `rdata` out 32: load result, valid while `ready` is high.
- `ready` out 1: one-cycle completion pulse.
- `err` out 1: fault flag, asserted only together with `ready`.
- `busy` out 1: high while a request is in flight.

## Operation
- FSM states: IDLE, WAIT, DONE.
- Accept: a request is accepted at a rising edge when `req` = 1 and state is IDLE or DONE. `addr`, `we`, `size`, `sign` and `wdata` are latched, and a fault is computed. Counter is loaded with WAIT_CYCLES. Next state is WAIT.
- WAIT: if the counter is 0, perform the access at this edge and go to DONE. Otherwise decrement the counter.
- DONE: `ready` = 1 for exactly this cycle. Next state is WAIT if a new request is accepted, otherwise IDLE.
- `req` in WAIT is ignored and not queued. The master holds or re-issues it.
- Fault if any of the following, with priority irrelevant because all faults behave the same:
  - `size` = 11.
  - halfword with `addr[0]` = 1.
  - word with `addr[1:0]` ≠ 0.
  - `addr[31:ADDR_W+2]` ≠ 0.
- On a fault: no array write, `rdata` = 0, `err` = 1 in DONE.
- Byte lanes are little-endian: lane k = bits [8k+7:8k], selected by `addr[1:0]`.
- Stores write only the addressed lanes; other lanes keep their value.
- Loads extract the addressed lanes and extend to 32 bits per `sign`. Word loads ignore `sign`.
- A store leaves `rdata` at 0 in DONE.
- Array contents are not reset and are undefined until written.

## Timing
- Reset values: state IDLE, counter 0, `ready` 0, `err` 0, `busy` 0, `rdata` 0.
- Reset asserted mid-operation aborts the access with no write. No `ready` pulse follows.
- `busy` = 1 in WAIT only, so it is low in IDLE and DONE.
- Latency: accept at edge E0 puts `ready` high in the cycle after edge E0 + WAIT_CYCLES + 1.
  - WAIT_CYCLES = 0: `ready` in the 2nd cycle after accept.
  - WAIT_CYCLES = 1: `ready` in the 3rd cycle after accept.
- Store data is visible to a load accepted in that store's DONE cycle.
- Throughput: one access per WAIT_CYCLES + 2 cycles with `req` held high.
- `rdata`, `ready`, `err` and `busy` are registered outputs with no combinational path from inputs.

## Structure
- Package `dmemx_pkg` holds:
  - the size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`;
  - the FSM state enum;
  - the lane-mask function (size + `addr[1:0]` → 4-bit byte enable).
- Sub-module `dmemx_ram` is the byte-enable synchronous-write, asynchronous-read array:
  - ports: clk, we, be[3:0], waddr/raddr[ADDR_W-1:0], wd[31:0], rd[31:0].
  - This keeps the array swappable for a vendor RAM macro.
- Top level holds the FSM, counter, request latch, fault check, store lane steering and load extraction/extension.

## Test plan
- Reset then word store of 0xDEADBEEF to 0x10, then word load of 0x10 (WAIT_CYCLES = 1):
  - `ready` in the 3rd cycle after each accept.
  - load returns 0xDEADBEEF, `err` = 0.
- Byte store 0x7F to 0x13, then loads:
  - word load of 0x10 returns 0x7FADBEEF.
  - byte load of 0x12 with `sign` = 1 returns 0xFFFFFFAD.
  - same load with `sign` = 0 returns 0x000000AD.
- Halfword load at 0x11:
  - `err` = 1 with `ready`, `rdata` = 0.
- Word store to 0x100 with ADDR_W = 6:
  - `err` = 1.
  - a subsequent word load of 0x000 shows no change.
- Hold `req` high for 4 back-to-back word loads (WAIT_CYCLES = 0):
  - `ready` every 2nd cycle.
  - `busy` high only in WAIT cycles.
  - requests in WAIT are not double-accepted.
- Assert `rst_n` low during WAIT of a store to 0x20:
  - no `ready` pulse.
  - a later load of 0x20 returns the pre-store value.
  - all outputs are 0 during reset.

Source files
------------

// File: rtl/dmemx_pkg.sv
// dmemx_pkg: shared definitions for the dmemx data memory.
//   - access-size encodings driven on the size port
//   - FSM state type
//   - lane_mask(): access size + byte offset -> 4-bit byte enable
package dmemx_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Little-endian lanes: lane k is bits [8k+7:8k].
    function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] lane);
        logic [3:0] m;
        m = 4'b0000;
        case (sz)
            SZ_BYTE: m = 4'b0001 << lane;
            SZ_HALF: m = lane[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmemx_ram.sv
// dmemx_ram: 32-bit word array, byte-enable synchronous write, asynchronous read.
// Kept separate so it can be replaced by a vendor RAM macro.
// Ports:
//   clk    in  write clock
//   we     in  write enable
//   be     in  [3:0] byte enables (lane k = bits [8k+7:8k])
//   waddr  in  [ADDR_W-1:0] word write address
//   raddr  in  [ADDR_W-1:0] word read address
//   wd     in  [31:0] write data, already steered onto lanes
//   rd     out [31:0] read data (combinational)
// Contents are not reset.
module dmemx_ram #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [31:0]       wd,
    output logic [31:0]       rd
);

    logic [31:0] r_mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) begin
                    r_mem[waddr][8*k +: 8] <= wd[8*k +: 8];
                end
            end
        end
    end

    assign rd = r_mem[raddr];

endmodule

// File: rtl/dmemx.sv
// dmemx: single-outstanding data memory for the MIPS memory stage.
// Byte/halfword/word loads and stores, programmable wait states, fault
// reporting for bad size, misalignment and out-of-range addresses.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   req              request valid (taken in IDLE or DONE only)
//   we               1 = store, 0 = load
//   size             00 byte, 01 half, 10 word, 11 illegal
//   sign             sign-extend sub-word loads
//   addr  [31:0]     byte address
//   wdata [31:0]     right-justified store data
//   rdata [31:0]     load result, valid with ready
//   ready            one-cycle completion pulse
//   err              fault flag, only with ready
//   busy             high while the access is waiting
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | nothing in flight, can accept
// WAIT  | request latched, counting wait states; access at count 0
// DONE  | ready/err/rdata presented this cycle, can accept again
module dmemx
    import dmemx_pkg::*;
#(
    parameter int ADDR_W      = 6,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_we;
    logic              r_sign;
    logic              r_fault;
    logic [1:0]        r_size;
    logic [ADDR_W+1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              r_ready;
    logic              r_err;
    logic              r_busy;

    logic              w_accept;
    logic              w_fault;
    logic              w_access;
    logic              w_ram_we;
    logic [3:0]        w_be;
    logic [31:0]       w_wd;
    logic [31:0]       w_rd;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load;
    logic [ADDR_W-1:0] w_word_addr;

    assign w_accept = req && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    // Any address bit above the array's byte range is a fault rather than an alias.
    assign w_fault = (size == SZ_BAD)
                   || ((size == SZ_HALF) && addr[0])
                   || ((size == SZ_WORD) && (addr[1:0] != 2'b00))
                   || ((addr >> (ADDR_W + 2)) != 32'd0);

    assign w_access    = (r_state == ST_WAIT) && (r_cnt == 4'd0);
    assign w_ram_we    = w_access && r_we && !r_fault;
    assign w_be        = lane_mask(r_size, r_addr[1:0]);
    assign w_word_addr = r_addr[ADDR_W+1:2];

    // Replicate sub-word store data on every lane; the byte enable picks the lane.
    always_comb begin
        w_wd = r_wdata;
        case (r_size)
            SZ_BYTE: w_wd = {4{r_wdata[7:0]}};
            SZ_HALF: w_wd = {2{r_wdata[15:0]}};
            default: w_wd = r_wdata;
        endcase
    end

    always_comb begin
        w_byte = w_rd[7:0];
        case (r_addr[1:0])
            2'd0: w_byte = w_rd[7:0];
            2'd1: w_byte = w_rd[15:8];
            2'd2: w_byte = w_rd[23:16];
            2'd3: w_byte = w_rd[31:24];
            default: w_byte = w_rd[7:0];
        endcase
        w_half = r_addr[1] ? w_rd[31:16] : w_rd[15:0];
        w_load = 32'd0;
        case (r_size)
            SZ_BYTE: w_load = {{24{r_sign & w_byte[7]}}, w_byte};
            SZ_HALF: w_load = {{16{r_sign & w_half[15]}}, w_half};
            SZ_WORD: w_load = w_rd;
            default: w_load = 32'd0;
        endcase
    end

    dmemx_ram #(
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (w_ram_we),
        .be    (w_be),
        .waddr (w_word_addr),
        .raddr (w_word_addr),
        .wd    (w_wd),
        .rd    (w_rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_sign  <= 1'b0;
            r_fault <= 1'b0;
            r_size  <= SZ_BYTE;
            r_addr  <= '0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_rdata <= 32'd0;
                    if (w_accept) begin
                        r_we    <= we;
                        r_sign  <= sign;
                        r_size  <= size;
                        r_addr  <= addr[ADDR_W+1:0];
                        r_wdata <= wdata;
                        r_fault <= w_fault;
                        r_cnt   <= LP_WAIT;
                        r_busy  <= 1'b1;
                        r_state <= ST_WAIT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_ready <= 1'b1;
                        r_err   <= r_fault;
                        r_rdata <= (r_we || r_fault) ? 32'd0 : w_load;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt   <= r_cnt - 4'd1;
                        r_busy  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rdata = r_rdata;
    assign ready = r_ready;
    assign err   = r_err;
    assign busy  = r_busy;

endmodule
